// File: rtl/vending_pkg.sv
// Shared types and coin codes for the vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A_C  = 2'b01;
  localparam logic [1:0] COIN_B_C  = 2'b10;
  localparam logic [1:0] COIN_C_C  = 2'b11;

endpackage

// File: rtl/vending_fsm_param_if.sv
// Coin/select/change handshake bundle between the host side and the controller.
interface vending_fsm_param_if #(
  parameter int CREDIT_W = 8,
  parameter int SEL_W    = 2
);
  logic [1:0]          coin;
  logic [SEL_W-1:0]    sel;
  logic                buy;
  logic                cancel;
  logic                change_ack;
  logic                dispense;
  logic [SEL_W-1:0]    dispense_item;
  logic                change_valid;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                deny;
  logic                busy;

  modport master (
    output coin, sel, buy, cancel, change_ack,
    input  dispense, dispense_item, change_valid, credit, coin_reject, deny, busy
  );

  modport slave (
    input  coin, sel, buy, cancel, change_ack,
    output dispense, dispense_item, change_valid, credit, coin_reject, deny, busy
  );
endinterface

// File: rtl/vend_coin_decode.sv
// Maps a two-bit coin code onto its rupee value; code 00 is worth nothing.
module vend_coin_decode
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 8,
  parameter int COIN_A   = 5,
  parameter int COIN_B   = 10,
  parameter int COIN_C   = 20
) (
  input  logic [1:0]          i_coin,
  output logic [CREDIT_W-1:0] o_value
);

  // Pure lookup of the coin code.
  always_comb begin
    o_value = '0;
    case (i_coin)
      COIN_A_C: o_value = CREDIT_W'(COIN_A);
      COIN_B_C: o_value = CREDIT_W'(COIN_B);
      COIN_C_C: o_value = CREDIT_W'(COIN_C);
      default:  o_value = '0;
    endcase
  end

endmodule

// File: rtl/vending_fsm_param.sv
// Multi-item vending controller: credit accumulation, vend, change payout.
//
//   state  | meaning
//   IDLE   | no credit held
//   CREDIT | credit > 0, accepting coins, buy or cancel
//   VEND   | single dispense cycle
//   CHANGE | returning credit one CHANGE_UNIT per ack
module vending_fsm_param
  import vending_pkg::*;
#(
  parameter int CREDIT_W    = 8,
  parameter int NUM_ITEMS   = 4,
  parameter int SEL_W       = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int COIN_A      = 5,
  parameter int COIN_B      = 10,
  parameter int COIN_C      = 20,
  parameter int CHANGE_UNIT = 5,
  parameter int MAX_CREDIT  = 50
) (
  input  logic                clk,
  input  logic                rst,
  vending_fsm_param_if.slave  bus
);

  state_e              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [SEL_W-1:0]    r_item;
  logic                r_reject;
  logic                r_deny;

  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_price;
  logic [SEL_W-1:0]    w_idx;
  logic                w_sel_ok;
  logic                w_afford;
  logic                w_fits;
  logic                w_coin_in;

  vend_coin_decode #(
    .CREDIT_W (CREDIT_W),
    .COIN_A   (COIN_A),
    .COIN_B   (COIN_B),
    .COIN_C   (COIN_C)
  ) u_coin_decode (
    .i_coin  (bus.coin),
    .o_value (w_coin_val)
  );

  // Out-of-range selections look up item 0 so the part-select never leaves the table;
  // they are refused through w_sel_ok anyway.
  assign w_sel_ok  = int'(bus.sel) < NUM_ITEMS;
  assign w_idx     = w_sel_ok ? bus.sel : '0;
  assign w_price   = PRICES[int'(w_idx)*CREDIT_W +: CREDIT_W];
  assign w_afford  = w_sel_ok && (r_credit >= w_price);
  assign w_sum     = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_fits    = w_sum <= (CREDIT_W+1)'(MAX_CREDIT);
  assign w_coin_in = bus.coin != COIN_NONE;

  // State, credit and event pulses; cancel beats buy beats coin.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_item   <= '0;
      r_reject <= 1'b0;
      r_deny   <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      r_deny   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_CREDIT: begin
          if (bus.cancel) begin
            r_reject <= w_coin_in;
            if (r_credit != '0) r_state <= ST_CHANGE;
          end else if (bus.buy) begin
            r_reject <= w_coin_in;
            if (w_afford) begin
              r_credit <= r_credit - w_price;
              r_item   <= bus.sel;
              r_state  <= ST_VEND;
            end else begin
              r_deny <= 1'b1;
            end
          end else if (w_coin_in) begin
            if (w_fits) begin
              r_credit <= w_sum[CREDIT_W-1:0];
              r_state  <= ST_CREDIT;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          r_reject <= w_coin_in;
          r_state  <= (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        end
        ST_CHANGE: begin
          r_reject <= w_coin_in;
          if (bus.change_ack) begin
            r_credit <= r_credit - CREDIT_W'(CHANGE_UNIT);
            if (r_credit == CREDIT_W'(CHANGE_UNIT)) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dispense      = (r_state == ST_VEND);
  assign bus.change_valid  = (r_state == ST_CHANGE);
  assign bus.busy          = (r_state == ST_VEND) || (r_state == ST_CHANGE);
  assign bus.dispense_item = r_item;
  assign bus.credit        = r_credit;
  assign bus.coin_reject   = r_reject;
  assign bus.deny          = r_deny;

endmodule

// File: doc/vending_fsm_param.md
# vending_fsm_param

Parametrised multi-item vending controller. Accumulates coin credit, vends one of `NUM_ITEMS` products at per-item prices, and returns change one unit per handshake. Supports cancel/refund and overpay rejection. It is the next-generation controller for the vending datapath; its outputs drive the dispenser and the change hopper directly.

## Interface

Parameters:

- `CREDIT_W`, 8: width of credit and price values. Units are rupees.
- `NUM_ITEMS`, 4: number of selectable products. Must be ≥ 1.
- `SEL_W`, 2: width of `sel`. Must be ≥ clog2(`NUM_ITEMS`) and ≥ 1.
- `PRICES`, {8'd25,8'd20,8'd15,8'd10}: flattened price table. Item i = `PRICES[i*CREDIT_W +: CREDIT_W]`, so item0 = 10, item1 = 15, item2 = 20, item3 = 25.
- `COIN_A`, 5: value of coin code 01.
- `COIN_B`, 10: value of coin code 10.
- `COIN_C`, 20: value of coin code 11.
- `CHANGE_UNIT`, 5: value returned per change handshake. All coin values and prices must be non-zero multiples of it.
- `MAX_CREDIT`, 50: credit ceiling. Must be < 2^`CREDIT_W`.

Ports:

- `clk` input 1: single clock. Everything is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `coin` input 2: coin code. 00 = none, 01 = `COIN_A`, 10 = `COIN_B`, 11 = `COIN_C`.
- `sel` input `SEL_W`: item index, sampled with `buy`.
- `buy` input 1: purchase request, one cycle.
- `cancel` input 1: refund request, one cycle.
- `change_ack` input 1: hopper accepted one change unit.
- `dispense` output 1: one-cycle vend pulse.
- `dispense_item` output `SEL_W`: item index. Valid while `dispense` = 1.
- `change_valid` output 1: one `CHANGE_UNIT` is pending return.
- `credit` output `CREDIT_W`: current credit.
- `coin_reject` output 1: one-cycle pulse when an inserted coin was returned unaccepted.
- `deny` output 1: one-cycle pulse when `buy` was refused.
- `busy` output 1: high in VEND and CHANGE.

## Operation

State machine:

- **IDLE**: credit = 0.
- **CREDIT**: credit > 0, accepting coins or a buy.
- **VEND**: lasts exactly one cycle; `dispense` = 1.
- **CHANGE**: `change_valid` = 1 until credit reaches 0.

Input priority in IDLE and CREDIT, in one cycle: `cancel` > `buy` > `coin`.

- **cancel**, credit > 0: go to CHANGE. Cancel with credit = 0 is ignored.
- **buy**:
  - If `sel` < `NUM_ITEMS` and credit ≥ price[sel]: credit ← credit − price, `dispense_item` ← sel, go to VEND.
  - Otherwise: pulse `deny` and keep state and credit unchanged.
- **coin ≠ 00**, no cancel or buy:
  - If credit + value ≤ `MAX_CREDIT`: credit ← credit + value, go to CREDIT.
  - Otherwise: pulse `coin_reject` and leave credit unchanged.
- A coin arriving in the same cycle as `cancel` or `buy` is rejected with `coin_reject`.
- The credit sum is computed at `CREDIT_W`+1 bits, so it never wraps.

VEND:

- Go to CHANGE if the remaining credit > 0, else go to IDLE.
- Inputs are ignored, except coins, which are rejected.

CHANGE:

- On `change_valid` && `change_ack`: credit ← credit − `CHANGE_UNIT`.
- On the ack that brings credit to 0: go to IDLE and drop `change_valid` in the following cycle.
- Coins are rejected. `buy` and `cancel` are ignored; they do not pulse `deny`.

Reset:

- Takes precedence over every input, from any state, including mid-CHANGE.
- Forces IDLE and credit = 0. Any change owed is forfeited.
- All outputs go to 0: `dispense`, `dispense_item`, `change_valid`, `credit`, `coin_reject`, `deny`, `busy`.

## Timing

- All outputs are registered. An input sampled at edge N is reflected in outputs during cycle N+1.
- `buy` at edge N: `dispense` high for cycle N+1 only. `change_valid` high from cycle N+2 if change is owed.
- `cancel` at edge N: `change_valid` high from cycle N+1.
- `change_valid` holds until acked; it does not drop without an ack. Ack while `change_valid` = 0 is ignored.
- Change throughput is one unit per cycle if `change_ack` is held high.
- `coin_reject` and `deny` are single-cycle pulses in cycle N+1.
- `credit` updates in cycle N+1 of the event that changes it.

## Structure

- Shared package `vending_pkg` holds:
  - the state enum (IDLE, CREDIT, VEND, CHANGE);
  - coin code constants (`COIN_NONE` = 00, `COIN_A_C` = 01, `COIN_B_C` = 10, `COIN_C_C` = 11).
- One sub-module, `vend_coin_decode`: a combinational mapping of `coin` to a value, with `COIN_A`/`COIN_B`/`COIN_C` passed as parameters.
- The price lookup stays inline as an indexed part-select.

## Test plan

1. **Exact pay**: coin 10 then coin 01 (credit 15), then buy sel=1 → `dispense` = 1 with item 1 one cycle later, credit = 0, return to IDLE, no `change_valid`.
2. **Overpay**: coin 11 (20), then buy sel=0 (price 10) → `dispense`, credit 10, then `change_valid` for two acked cycles (credit 10 → 5 → 0), then IDLE.
3. **Insufficient and invalid**: credit 5, buy sel=3 → `deny` pulse, credit stays 5. Repeat with `NUM_ITEMS` = 3 and sel = 3 → `deny`.
4. **Ceiling**: three coin 11 (20+20, then the third rejected) → `coin_reject` on the third, credit = 40. Then coin 10 → credit 50.
5. **Cancel with stalled hopper**: credit 15, cancel, `change_ack` low for 4 cycles → `change_valid` holds, credit stays 15. Then ack held for 3 cycles → credit 0, IDLE, and coins inserted during CHANGE are rejected.
6. **Reset and simultaneous events**: reset mid-CHANGE → all outputs 0 next cycle. Buy+coin in the same cycle → vend proceeds and `coin_reject` pulses.
